// File: rtl/moore_tally_counter.sv
// Up/down tally counter with tick-qualified requests, saturating or wrapping limits,
// a ripple-maintained BCD image for the display path, and a Moore occupancy state.
module moore_tally_counter #(
  parameter int unsigned MAX_COUNT = 3,
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned WRAP      = 0,
  parameter int unsigned EDGE      = 1,
  parameter int unsigned CW        = $clog2(MAX_COUNT + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  inc,
  input  logic                  dec,
  input  logic                  clr,
  output logic [CW-1:0]         count,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [1:0]            state,
  output logic                  full,
  output logic                  empty,
  output logic                  ovf
);

  localparam int unsigned BW = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_MID   = 2'd1,
    S_FULL  = 2'd2,
    S_BAD   = 2'd3
  } state_e;

  // Elaboration-time decimal image of a constant (used only for MAX_COUNT)
  function automatic logic [BW-1:0] const_bcd(input int unsigned v);
    logic [BW-1:0] r;
    int unsigned   x;
    r = '0;
    x = v;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  localparam logic [BW-1:0] MAX_BCD = const_bcd(MAX_COUNT);

  function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    logic          carry;
    r     = b;
    carry = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (b[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = b[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [BW-1:0] bcd_dec(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    logic          borrow;
    r      = b;
    borrow = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (b[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = b[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  state_e          state_q, state_nxt;
  logic [CW-1:0]   count_nxt;
  logic [BW-1:0]   bcd_nxt;
  logic            ovf_nxt;
  logic            inc_prev, dec_prev;
  logic            inc_q, dec_q;
  logic            at_max, at_zero;

  assign state = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_EMPTY;
      count    <= '0;
      bcd      <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      ovf      <= 1'b0;
      inc_prev <= 1'b0;
      dec_prev <= 1'b0;
    end else begin
      state_q <= state_nxt;
      count   <= count_nxt;
      bcd     <= bcd_nxt;
      full    <= (state_nxt == S_FULL);
      empty   <= (state_nxt == S_EMPTY);
      ovf     <= ovf_nxt;
      if (tick) begin
        inc_prev <= inc;
        dec_prev <= dec;
      end
    end
  end

  // Request qualification, priority resolution and next count/BCD/state
  always_comb begin
    count_nxt = count;
    bcd_nxt   = bcd;
    ovf_nxt   = ovf;
    state_nxt = state_q;
    inc_q     = (EDGE != 0) ? (inc & ~inc_prev) : inc;
    dec_q     = (EDGE != 0) ? (dec & ~dec_prev) : dec;
    at_max    = (count == CW'(MAX_COUNT));
    at_zero   = (count == '0);

    if (state_q == S_BAD) begin
      count_nxt = '0;
      bcd_nxt   = '0;
    end else if (tick) begin
      if (clr) begin
        // clr together with a qualified request is the legacy hold case
        if (!inc_q && !dec_q) begin
          count_nxt = '0;
          bcd_nxt   = '0;
          ovf_nxt   = 1'b0;
        end
      end else if (inc_q && !dec_q) begin
        if (at_max) begin
          ovf_nxt = 1'b1;
          if (WRAP != 0) begin
            count_nxt = '0;
            bcd_nxt   = '0;
          end
        end else begin
          count_nxt = count + CW'(1);
          bcd_nxt   = bcd_inc(bcd);
        end
      end else if (dec_q && !inc_q) begin
        if (at_zero) begin
          ovf_nxt = 1'b1;
          if (WRAP != 0) begin
            count_nxt = CW'(MAX_COUNT);
            bcd_nxt   = MAX_BCD;
          end
        end else begin
          count_nxt = count - CW'(1);
          bcd_nxt   = bcd_dec(bcd);
        end
      end
    end

    if (count_nxt == '0) begin
      state_nxt = S_EMPTY;
    end else if (count_nxt == CW'(MAX_COUNT)) begin
      state_nxt = S_FULL;
    end else begin
      state_nxt = S_MID;
    end
  end

endmodule

// File: tb/tb_moore_tally_counter.sv
// Scoreboard bench for moore_tally_counter: three configurations share one stimulus
// stream; a behavioural model per instance predicts every registered output.
module tb_moore_tally_counter;

  typedef struct packed {
    logic [7:0]  cnt;
    logic [15:0] bcd;
    logic [1:0]  st;
    logic        full;
    logic        empty;
    logic        ovf;
  } vec_t;

  typedef struct {
    int unsigned cnt;
    logic        ovf;
    logic        ip;
    logic        dp;
  } mdl_t;

  logic clk, reset, tick, inc, dec, clr;

  logic [1:0]  c0_count, c1_count;
  logic [3:0]  c2_count;
  logic [15:0] c0_bcd, c1_bcd;
  logic [7:0]  c2_bcd;
  logic [1:0]  c0_state, c1_state, c2_state;
  logic        c0_full, c1_full, c2_full;
  logic        c0_empty, c1_empty, c2_empty;
  logic        c0_ovf, c1_ovf, c2_ovf;

  int unsigned mx [3] = '{3, 3, 12};
  bit          wr [3] = '{1'b0, 1'b0, 1'b1};
  bit          ed [3] = '{1'b1, 1'b0, 1'b1};
  mdl_t        mdl [3];
  vec_t        sbq [$];
  int          errors = 0;
  int          checks = 0;

  moore_tally_counter #(.MAX_COUNT(3), .DIGITS(4), .WRAP(0), .EDGE(1)) u_sat (
    .clk(clk), .reset(reset), .tick(tick), .inc(inc), .dec(dec), .clr(clr),
    .count(c0_count), .bcd(c0_bcd), .state(c0_state),
    .full(c0_full), .empty(c0_empty), .ovf(c0_ovf));

  moore_tally_counter #(.MAX_COUNT(3), .DIGITS(4), .WRAP(0), .EDGE(0)) u_lvl (
    .clk(clk), .reset(reset), .tick(tick), .inc(inc), .dec(dec), .clr(clr),
    .count(c1_count), .bcd(c1_bcd), .state(c1_state),
    .full(c1_full), .empty(c1_empty), .ovf(c1_ovf));

  moore_tally_counter #(.MAX_COUNT(12), .DIGITS(2), .WRAP(1), .EDGE(1)) u_wrap (
    .clk(clk), .reset(reset), .tick(tick), .inc(inc), .dec(dec), .clr(clr),
    .count(c2_count), .bcd(c2_bcd), .state(c2_state),
    .full(c2_full), .empty(c2_empty), .ovf(c2_ovf));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, required finish");
    $fatal(1, "timeout");
  end

  function automatic mdl_t mstep(input mdl_t m, input int unsigned mxv, input bit wrp,
                                 input bit edg, input logic t, input logic i,
                                 input logic d, input logic c);
    mdl_t r;
    logic iq, dq;
    r = m;
    if (!t) return r;
    iq = edg ? (i && !m.ip) : i;
    dq = edg ? (d && !m.dp) : d;
    r.ip = i;
    r.dp = d;
    if (c) begin
      if (!iq && !dq) begin
        r.cnt = 0;
        r.ovf = 1'b0;
      end
    end else if (iq && !dq) begin
      if (m.cnt == mxv) begin
        r.ovf = 1'b1;
        if (wrp) r.cnt = 0;
      end else r.cnt = m.cnt + 1;
    end else if (dq && !iq) begin
      if (m.cnt == 0) begin
        r.ovf = 1'b1;
        if (wrp) r.cnt = mxv;
      end else r.cnt = m.cnt - 1;
    end
    return r;
  endfunction

  function automatic vec_t expect_of(input int k);
    vec_t        v;
    int unsigned c;
    c       = mdl[k].cnt;
    v.cnt   = 8'(c);
    v.bcd   = {4'((c / 1000) % 10), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
    v.st    = (c == 0) ? 2'd0 : ((c == mx[k]) ? 2'd2 : 2'd1);
    v.full  = (c == mx[k]);
    v.empty = (c == 0);
    v.ovf   = mdl[k].ovf;
    return v;
  endfunction

  function automatic vec_t obs(input int k);
    vec_t v;
    case (k)
      0: v = '{cnt: 8'(c0_count), bcd: c0_bcd, st: c0_state,
               full: c0_full, empty: c0_empty, ovf: c0_ovf};
      1: v = '{cnt: 8'(c1_count), bcd: c1_bcd, st: c1_state,
               full: c1_full, empty: c1_empty, ovf: c1_ovf};
      default: v = '{cnt: 8'(c2_count), bcd: 16'(c2_bcd), st: c2_state,
                     full: c2_full, empty: c2_empty, ovf: c2_ovf};
    endcase
    return v;
  endfunction

  task automatic clear_models();
    for (int j = 0; j < 3; j++) begin
      mdl[j].cnt = 0;
      mdl[j].ovf = 1'b0;
      mdl[j].ip  = 1'b0;
      mdl[j].dp  = 1'b0;
    end
  endtask

  // One clock of stimulus; the prediction for instance k joins the scoreboard
  task automatic drive(input int k, input logic t, input logic i, input logic d, input logic c);
    @(negedge clk);
    tick = t; inc = i; dec = d; clr = c;
    for (int j = 0; j < 3; j++) mdl[j] = mstep(mdl[j], mx[j], wr[j], ed[j], t, i, d, c);
    sbq.push_back(expect_of(k));
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    tick = 1'b0; inc = 1'b0; dec = 1'b0; clr = 1'b0;
    clear_models();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    vec_t e, o;
    reset = 1'b1;
    tick = 1'b0; inc = 1'b0; dec = 1'b0; clr = 1'b0;
    clear_models();
    #2;
    for (int k = 0; k < 3; k++) begin
      sbq.push_back(expect_of(k));
      e = sbq.pop_front();
      o = obs(k);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset dut%0d: got %h, expected %h", k, o, e);
      end
    end
    checks++;
    if (c0_empty !== 1'b1 || c0_full !== 1'b0 || c0_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_flags: got empty=%b full=%b state=%0d, expected 1 0 0",
               c0_empty, c0_full, c0_state);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_saturate();
    vec_t e, o;
    logic [3:0] seq [$];
    seq = '{4'b1100, 4'b0000, 4'b1000};
    for (int p = 0; p < 4; p++) begin
      foreach (seq[n]) begin
        drive(0, seq[n][3], seq[n][2], seq[n][1], seq[n][0]);
        e = sbq.pop_front();
        o = obs(0);
        checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL saturate p%0d s%0d: got %h, expected %h", p, n, o, e);
        end
      end
    end
    checks++;
    if (c0_count !== 2'd3 || c0_state !== 2'd2 || c0_ovf !== 1'b1 || c0_bcd !== 16'h0003) begin
      errors++;
      $display("FAIL saturate_end: got count=%0d state=%0d ovf=%b bcd=%h, expected 3 2 1 0003",
               c0_count, c0_state, c0_ovf, c0_bcd);
    end
  endtask

  task automatic test_clear_hold();
    vec_t e, o;
    logic [3:0] seq [$];
    seq = '{4'b1010, 4'b1000, 4'b1001, 4'b1000, 4'b1100, 4'b1000, 4'b1100, 4'b1000, 4'b1101};
    foreach (seq[n]) begin
      drive(0, seq[n][3], seq[n][2], seq[n][1], seq[n][0]);
      e = sbq.pop_front();
      o = obs(0);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL clear_hold s%0d: got %h, expected %h", n, o, e);
      end
      if (n == 2) begin
        checks++;
        if (c0_count !== 2'd0 || c0_ovf !== 1'b0 || c0_state !== 2'd0) begin
          errors++;
          $display("FAIL clear: got count=%0d ovf=%b state=%0d, expected 0 0 0",
                   c0_count, c0_ovf, c0_state);
        end
      end
    end
    checks++;
    if (c0_count !== 2'd2) begin
      errors++;
      $display("FAIL clr_inc_hold: got count=%0d, expected 2", c0_count);
    end
  endtask

  task automatic test_edge();
    vec_t e, o;
    apply_reset();
    for (int n = 0; n < 10; n++) begin
      drive(0, 1'b1, 1'b1, 1'b0, 1'b0);
      e = sbq.pop_front();
      o = obs(0);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL edge t%0d: got %h, expected %h", n, o, e);
      end
    end
    checks++;
    if (c0_count !== 2'd1) begin
      errors++;
      $display("FAIL edge_once: got count=%0d, expected 1", c0_count);
    end
  endtask

  task automatic test_level();
    vec_t e, o;
    apply_reset();
    for (int n = 0; n < 10; n++) begin
      drive(1, 1'b1, 1'b1, 1'b0, 1'b0);
      e = sbq.pop_front();
      o = obs(1);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL level t%0d: got %h, expected %h", n, o, e);
      end
      if (n == 2) begin
        checks++;
        if (c1_count !== 2'd3 || c1_full !== 1'b1) begin
          errors++;
          $display("FAIL level_3ticks: got count=%0d full=%b, expected 3 1", c1_count, c1_full);
        end
      end
    end
    checks++;
    if (c1_count !== 2'd3 || c1_ovf !== 1'b1) begin
      errors++;
      $display("FAIL level_sat: got count=%0d ovf=%b, expected 3 1", c1_count, c1_ovf);
    end
  endtask

  task automatic test_wrap_bcd();
    vec_t e, o;
    logic [7:0] want;
    apply_reset();
    for (int p = 1; p <= 13; p++) begin
      drive(2, 1'b1, 1'b1, 1'b0, 1'b0);
      e = sbq.pop_front();
      o = obs(2);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL wrap_inc p%0d: got %h, expected %h", p, o, e);
      end
      if (p == 9 || p == 10 || p == 12 || p == 13) begin
        want = (p == 9) ? 8'h09 : (p == 10) ? 8'h10 : (p == 12) ? 8'h12 : 8'h00;
        checks++;
        if (c2_bcd !== want) begin
          errors++;
          $display("FAIL wrap_bcd p%0d: got %h, expected %h", p, c2_bcd, want);
        end
      end
      drive(2, 1'b1, 1'b0, 1'b0, 1'b0);
      e = sbq.pop_front();
      o = obs(2);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL wrap_idle p%0d: got %h, expected %h", p, o, e);
      end
    end
    checks++;
    if (c2_ovf !== 1'b1 || c2_count !== 4'd0) begin
      errors++;
      $display("FAIL wrap_ovf: got count=%0d ovf=%b, expected 0 1", c2_count, c2_ovf);
    end
    for (int p = 0; p < 4; p++) begin
      drive(2, 1'b1, 1'b0, 1'b1, 1'b0);
      e = sbq.pop_front();
      o = obs(2);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL wrap_dec p%0d: got %h, expected %h", p, o, e);
      end
      if (p == 0) begin
        checks++;
        if (c2_count !== 4'd12 || c2_bcd !== 8'h12) begin
          errors++;
          $display("FAIL underflow_wrap: got count=%0d bcd=%h, expected 12 12", c2_count, c2_bcd);
        end
      end
      drive(2, 1'b1, 1'b0, 1'b0, 1'b0);
      void'(sbq.pop_front());
    end
    checks++;
    if (c2_bcd !== 8'h09) begin
      errors++;
      $display("FAIL bcd_borrow: got %h, expected 09", c2_bcd);
    end
  endtask

  task automatic test_simultaneous();
    vec_t e, o;
    logic [3:0] seq [$];
    apply_reset();
    seq = '{4'b1100, 4'b1000, 4'b1110, 4'b1000};
    foreach (seq[n]) begin
      drive(0, seq[n][3], seq[n][2], seq[n][1], seq[n][0]);
      e = sbq.pop_front();
      o = obs(0);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL simultaneous s%0d: got %h, expected %h", n, o, e);
      end
    end
    checks++;
    if (c0_count !== 2'd1) begin
      errors++;
      $display("FAIL inc_dec_same_tick: got count=%0d, expected 1", c0_count);
    end
  endtask

  task automatic test_async_reset();
    vec_t e, o;
    logic [3:0] seq [$];
    apply_reset();
    seq = '{4'b1010, 4'b1000, 4'b1100, 4'b1000, 4'b1100, 4'b1000};
    foreach (seq[n]) begin
      drive(0, seq[n][3], seq[n][2], seq[n][1], seq[n][0]);
      e = sbq.pop_front();
      o = obs(0);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL pre_reset s%0d: got %h, expected %h", n, o, e);
      end
    end
    // Assert between edges and look before the next rising edge
    @(negedge clk);
    #2;
    reset = 1'b1;
    tick = 1'b0; inc = 1'b1;
    clear_models();
    sbq.push_back(expect_of(0));
    #1;
    e = sbq.pop_front();
    o = obs(0);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL async_reset: got %h, expected %h", o, e);
    end
    @(negedge clk);
    reset = 1'b0;
    drive(0, 1'b1, 1'b1, 1'b0, 1'b0);
    e = sbq.pop_front();
    o = obs(0);
    checks++;
    if (o !== e || c0_count !== 2'd1) begin
      errors++;
      $display("FAIL first_tick_after_reset: got %h, expected %h", o, e);
    end
  endtask

  task automatic test_tick_gate();
    vec_t e, o;
    int   bad;
    bad = 0;
    for (int n = 0; n < 50; n++) begin
      drive(0, 1'b0, n[0], 1'b0, 1'b0);
      e = sbq.pop_front();
      o = obs(0);
      checks++;
      if (o !== e) begin
        errors++;
        bad++;
        if (bad <= 3) $display("FAIL tick_gate c%0d: got %h, expected %h", n, o, e);
      end
    end
    checks++;
    if (c0_count !== 2'd1) begin
      errors++;
      $display("FAIL tick_gate_hold: got count=%0d, expected 1", c0_count);
    end
  endtask

  initial begin
    test_reset();
    test_saturate();
    test_clear_hold();
    test_edge();
    test_level();
    test_wrap_bcd();
    test_simultaneous();
    test_async_reset();
    test_tick_gate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/moore_tally_counter.md
Name: moore_tally_counter

Overview:
- Parametrised successor of the single-channel coin/pulse Moore counter that feeds the Basys 3 seven-segment path.
- Counts qualified increment and decrement events up to MAX_COUNT, either saturating or wrapping, with a synchronous clear.
- Maintains a parallel BCD image of the count for direct connection to the display multiplexer.
- Runs on the single system clock; the slow sampling clock is replaced by a one-cycle tick enable.

Parameters:
- MAX_COUNT, 3, highest count value; legal range 1..(10^DIGITS - 1).
- DIGITS, 4, number of BCD digits produced on bcd; legal range 1..4.
- WRAP, 0, 0 = saturate at the limits; 1 = wrap (MAX_COUNT+1 goes to 0, 0-1 goes to MAX_COUNT).
- EDGE, 1, 1 = act on the rising edge of inc/dec as seen at successive ticks; 0 = act on level at every tick.
- CW, $clog2(MAX_COUNT+1), count width; derived, do not override.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- tick  in  1  sample enable; inc/dec/clr are evaluated only in cycles where tick=1.
- inc  in  1  increment request (legacy B).
- dec  in  1  decrement request.
- clr  in  1  clear request (legacy A); level-sensitive, never edge-qualified.
- count  out  CW  binary count.
- bcd  out  4*DIGITS  BCD digits of count; digit 0 (units) in [3:0].
- state  out  2  Moore state code: 0 EMPTY, 1 MID, 2 FULL.
- full  out  1  count == MAX_COUNT.
- empty  out  1  count == 0.
- ovf  out  1  sticky over/underflow flag.

Behaviour:
- Reset (async, active-high): count=0, bcd=0, state=EMPTY, empty=1, full=0, ovf=0. Edge history registers are cleared to 0.
- All outputs are registered. An event sampled in tick cycle n is visible on count, bcd, state, full, empty and ovf at the clk edge ending cycle n.
- Qualification with EDGE=1:
  - inc_q = inc & ~inc_prev, where inc_prev is updated only on tick.
  - dec_q is formed the same way from dec.
  - A request held high across many ticks counts once.
- Qualification with EDGE=0: inc_q = inc and dec_q = dec.
- Priority on each tick:
  1. clr=1 and inc_q=0 and dec_q=0: count becomes 0 and ovf is cleared.
  2. clr=1 together with inc_q or dec_q: no change (preserves the legacy A&B hold).
  3. inc_q and dec_q both 1: no change.
  4. inc_q alone: increment.
  5. dec_q alone: decrement.
  6. Nothing asserted: hold.
- Increment at FULL:
  - WRAP=0: count holds at MAX_COUNT and ovf is set.
  - WRAP=1: count becomes 0 and ovf is set.
- Decrement at EMPTY:
  - WRAP=0: count holds at 0 and ovf is set.
  - WRAP=1: count becomes MAX_COUNT and ovf is set.
- ovf is sticky. It is cleared only by a case-1 clr or by reset.
- BCD image:
  - Updated by a BCD increment/decrement ripple in the same cycle as count. No division or binary-to-BCD conversion is used.
  - Wrap to 0 loads all digits with 0. Wrap to MAX_COUNT loads the BCD constant of MAX_COUNT, computed at elaboration.
  - Digits above DIGITS are not generated.
- State machine (Moore; next state is derived from the next count):
  - EMPTY goes to MID when count becomes 1 and MAX_COUNT > 1. It goes directly to FULL when MAX_COUNT = 1.
  - MID goes to FULL when count reaches MAX_COUNT and to EMPTY when count reaches 0.
  - FULL goes to EMPTY on clr or wrap, and to MID on decrement.
  - The unused code 3 recovers to EMPTY with count=0 on the next clk.
  - full and empty are decoded from the registered state.
- tick=0: every register holds, including edge history.
- Reset asserted mid-count forces the reset values immediately, without waiting for clk. The first tick after release uses inc_prev=0.

Test Plan:
- Saturate, MAX_COUNT=3, WRAP=0, EDGE=1: four inc pulses, each a single tick with a low tick between -> count 1,2,3,3; state ends FULL (2); ovf=1 after the 4th pulse; bcd=0x0003.
- Clear and hold, from count=2: clr=1,inc=0 at a tick -> count=0, EMPTY, ovf=0. clr=1,inc=1 at a tick -> count unchanged.
- Edge qualification, EDGE=1: inc held high for 10 ticks -> count advances exactly 1.
- Level mode, EDGE=0: inc held high for 10 ticks with MAX_COUNT=3 -> saturates at 3 after 3 ticks.
- Wrap and BCD, MAX_COUNT=12, WRAP=1, DIGITS=2:
  - 13 inc pulses from 0 -> bcd passes 0x09 then 0x10, reaches 0x12, then returns to 0x00 with ovf=1.
  - dec at 0 -> count=12, bcd=0x12.
- Simultaneous events and async reset:
  - inc and dec pulse on the same tick -> no change.
  - reset asserted between clk edges at count=2 -> count=0, ovf=0 before the next edge.
  - A tick held 0 for 50 cycles while inc toggles -> no change.
